// File: rtl/alu_pkg.sv
// Shared ALU types: opcode enum, command record and the command sequencer's FSM states.
// Used by the ALU, the command sequencer and its testbench.
package alu_pkg;

  localparam int OPCODE_W = 3;
  // Operand width carried inside alu_cmd_t; the sequencer's WIDTH must match it.
  localparam int DATA_W   = 8;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_MUL  = 3'd5,
    OP_SHL  = 3'd6,
    OP_PASS = 3'd7
  } alu_opcode_e;

  typedef struct packed {
    alu_opcode_e       opcode;
    logic [DATA_W-1:0] operand1;
    logic [DATA_W-1:0] operand2;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the sequencer's command, ALU and result signals.
// slave is the sequencer side; master is the environment (source, ALU, sink).
interface alu_cmd_sequencer_if import alu_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter int RES_WIDTH = 16,
  parameter int DEPTH     = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  alu_opcode_e          in_opcode;
  logic [WIDTH-1:0]     in_operand1;
  logic [WIDTH-1:0]     in_operand2;
  logic [WIDTH-1:0]     alu_operand1;
  logic [WIDTH-1:0]     alu_operand2;
  alu_opcode_e          alu_opcode;
  logic [RES_WIDTH-1:0] alu_result;
  logic                 out_valid;
  logic                 out_ready;
  logic [RES_WIDTH-1:0] out_result;
  alu_opcode_e          out_opcode;
  logic [LVL_W-1:0]     level;

  modport slave (
    input  flush, in_valid, in_opcode, in_operand1, in_operand2, alu_result, out_ready,
    output in_ready, alu_operand1, alu_operand2, alu_opcode, out_valid, out_result,
           out_opcode, level
  );

  modport master (
    output flush, in_valid, in_opcode, in_operand1, in_operand2, alu_result, out_ready,
    input  in_ready, alu_operand1, alu_operand2, alu_opcode, out_valid, out_result,
           out_opcode, level
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH x alu_cmd_t with a separate occupancy counter so full/empty never alias.
// No bypass: a push is refused while full even if a pop happens in the same cycle.
module alu_cmd_fifo import alu_pkg::*; #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  alu_cmd_t         push_data,
  output logic             full,
  input  logic             pop,
  output alu_cmd_t         head,
  output logic [LVL_W-1:0] level
);

  alu_cmd_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && (level != '0) && !flush;
  assign head    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is not reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Clocked front end for the combinational ALU: queues commands, drives registered ALU inputs
// for one full cycle, then captures the result into a held valid/ready output.
module alu_cmd_sequencer import alu_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter int RES_WIDTH = 16,
  parameter int DEPTH     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_cmd_sequencer_if.slave  bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  seq_state_e           state_q;
  logic [WIDTH-1:0]     alu_op1_q;
  logic [WIDTH-1:0]     alu_op2_q;
  alu_opcode_e          alu_opc_q;
  logic [RES_WIDTH-1:0] result_q;
  alu_opcode_e          res_opc_q;
  logic                 out_valid_q;

  alu_cmd_t         push_data;
  alu_cmd_t         head;
  logic             full;
  logic             pop;
  logic             has_cmd;
  logic [LVL_W-1:0] level;

  assign push_data = '{opcode: bus.in_opcode, operand1: bus.in_operand1, operand2: bus.in_operand2};
  assign has_cmd   = (level != '0);
  // Pop exactly when the FSM loads the ALU registers; the FIFO itself masks pops during flush.
  assign pop = has_cmd && ((state_q == ST_IDLE) ||
                           (state_q == ST_HOLD && out_valid_q && bus.out_ready));

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .push      (bus.in_valid),
    .push_data (push_data),
    .full      (full),
    .pop       (pop),
    .head      (head),
    .level     (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      alu_opc_q   <= OP_ADD;
      result_q    <= '0;
      res_opc_q   <= OP_ADD;
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      // ALU and result registers keep their values; they are meaningless while out_valid is low.
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (has_cmd) begin
            alu_op1_q <= head.operand1;
            alu_op2_q <= head.operand2;
            alu_opc_q <= head.opcode;
            state_q   <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          result_q    <= bus.alu_result;
          res_opc_q   <= alu_opc_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (has_cmd) begin
              alu_op1_q <= head.operand1;
              alu_op2_q <= head.operand2;
              alu_opc_q <= head.opcode;
              state_q   <= ST_DRIVE;
            end else begin
              state_q   <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = !full;
  assign bus.level        = level;
  assign bus.alu_operand1 = alu_op1_q;
  assign bus.alu_operand2 = alu_op2_q;
  assign bus.alu_opcode   = alu_opc_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = result_q;
  assign bus.out_opcode   = res_opc_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: table of single-command vectors plus
// hand-written backpressure, hold, wrap-around, flush and async-reset sequences.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int WIDTH     = 8;
  localparam int RES_WIDTH = 16;
  localparam int DEPTH     = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  alu_cmd_sequencer_if #(.WIDTH(WIDTH), .RES_WIDTH(RES_WIDTH), .DEPTH(DEPTH)) bus ();

  alu_cmd_sequencer #(.WIDTH(WIDTH), .RES_WIDTH(RES_WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU, also used as the environment's ALU.
  function automatic logic [15:0] alu_ref(input alu_opcode_e op, input logic [7:0] a,
                                          input logic [7:0] b);
    logic [15:0] r;
    case (op)
      OP_ADD:  r = {8'h00, a} + {8'h00, b};
      OP_SUB:  r = {8'h00, a} - {8'h00, b};
      OP_AND:  r = {8'h00, a & b};
      OP_OR:   r = {8'h00, a | b};
      OP_XOR:  r = {8'h00, a ^ b};
      OP_MUL:  r = {8'h00, a} * {8'h00, b};
      OP_SHL:  r = {8'h00, a} << b[2:0];
      OP_PASS: r = {8'h00, a};
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  assign bus.alu_result = alu_ref(bus.alu_opcode, bus.alu_operand1, bus.alu_operand2);

  int checks = 0;
  int errors = 0;
  int n_results = 0;

  alu_cmd_t pend[$];
  alu_cmd_t exp_q[$];

  typedef struct {
    alu_opcode_e op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t     vecs[11];
  alu_cmd_t fill[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input alu_cmd_t c);
    bus.in_valid    = 1'b1;
    bus.in_opcode   = c.opcode;
    bus.in_operand1 = c.operand1;
    bus.in_operand2 = c.operand2;
  endtask

  // One command into an idle, empty unit with out_ready high: pop at N+1, result at N+2.
  task automatic single(input vec_t v);
    drive_cmd('{opcode: v.op, operand1: v.a, operand2: v.b});
    check("single_in_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    check("single_level_after_push", bus.level, 1);
    check("single_no_early_valid", bus.out_valid, 0);
    step();
    check("single_valid_low_in_drive", bus.out_valid, 0);
    check("single_level_after_pop", bus.level, 0);
    check("single_alu_opcode", bus.alu_opcode, v.op);
    check("single_alu_operand1", bus.alu_operand1, v.a);
    check("single_alu_operand2", bus.alu_operand2, v.b);
    step();
    check("single_out_valid", bus.out_valid, 1);
    check("single_out_result", bus.out_result, v.exp);
    check("single_out_opcode", bus.out_opcode, v.op);
    step();
    check("single_valid_cleared", bus.out_valid, 0);
  endtask

  // Scoreboarded streaming: sends pend, checks every handshaked result against exp_q in order.
  task automatic stream(input int budget, input bit toggle);
    alu_cmd_t e;
    int cyc;
    cyc = 0;
    while ((pend.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      bus.out_ready = toggle ? cyc[0] : 1'b1;
      if (pend.size() > 0) drive_cmd(pend[0]);
      else bus.in_valid = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        n_results++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_unexpected_result: got %0h expected none", bus.out_result);
        end else begin
          e = exp_q.pop_front();
          check("stream_result", bus.out_result, alu_ref(e.opcode, e.operand1, e.operand2));
          check("stream_opcode", bus.out_opcode, e.opcode);
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(pend.pop_front());
      step();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    if (pend.size() > 0 || exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: got %0d outstanding expected 0", pend.size() + exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{OP_ADD,  8'h05, 8'h03, 16'h0008};
    vecs[1]  = '{OP_ADD,  8'hFF, 8'h01, 16'h0100};
    vecs[2]  = '{OP_SUB,  8'h09, 8'h04, 16'h0005};
    vecs[3]  = '{OP_SUB,  8'h00, 8'h01, 16'hFFFF};
    vecs[4]  = '{OP_AND,  8'hF0, 8'h3C, 16'h0030};
    vecs[5]  = '{OP_OR,   8'hF0, 8'h0F, 16'h00FF};
    vecs[6]  = '{OP_XOR,  8'hAA, 8'hFF, 16'h0055};
    vecs[7]  = '{OP_MUL,  8'hFF, 8'hFF, 16'hFE01};
    vecs[8]  = '{OP_MUL,  8'h10, 8'h10, 16'h0100};
    vecs[9]  = '{OP_SHL,  8'h81, 8'h01, 16'h0102};
    vecs[10] = '{OP_PASS, 8'h5A, 8'h00, 16'h005A};

    fill[0] = '{OP_ADD, 8'h11, 8'h22};
    fill[1] = '{OP_SUB, 8'h40, 8'h01};
    fill[2] = '{OP_MUL, 8'h03, 8'h07};
    fill[3] = '{OP_XOR, 8'h0F, 8'hF0};
    fill[4] = '{OP_OR,  8'h80, 8'h01};
    fill[5] = '{OP_SHL, 8'h01, 8'h07};

    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_opcode   = OP_ADD;
    bus.in_operand1 = '0;
    bus.in_operand2 = '0;
    bus.out_ready   = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    step();
    step();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_level", bus.level, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_alu_operand1", bus.alu_operand1, 0);
    check("rst_alu_operand2", bus.alu_operand2, 0);
    check("rst_alu_opcode", bus.alu_opcode, 0);
    check("rst_out_result", bus.out_result, 0);
    check("rst_out_opcode", bus.out_opcode, 0);
    rst_n = 1'b1;
    step();

    // Table-driven single commands
    for (int i = 0; i < 11; i++) single(vecs[i]);

    // Fill under backpressure: 5 accepted (1 in flight + 4 queued), 6th held
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_cmd(fill[k]);
      check("fill_in_ready_open", bus.in_ready, 1);
      step();
    end
    drive_cmd(fill[5]);
    check("fill_in_ready_full", bus.in_ready, 0);
    check("fill_level_full", bus.level, 4);
    check("fill_out_valid", bus.out_valid, 1);

    // Hold stability while out_ready stays low
    for (int c = 0; c < 10; c++) begin
      step();
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_out_result", bus.out_result,
            alu_ref(fill[0].opcode, fill[0].operand1, fill[0].operand2));
      check("hold_out_opcode", bus.out_opcode, fill[0].opcode);
      check("hold_alu_operand1", bus.alu_operand1, fill[0].operand1);
      check("hold_alu_operand2", bus.alu_operand2, fill[0].operand2);
      check("hold_alu_opcode", bus.alu_opcode, fill[0].opcode);
      check("hold_level", bus.level, 4);
      check("hold_in_ready", bus.in_ready, 0);
    end

    // Drain in order; the held 6th command gets in once a slot frees
    for (int k = 0; k < 5; k++) exp_q.push_back(fill[k]);
    pend.push_back(fill[5]);
    n_results = 0;
    stream(60, 1'b0);
    check("drain_count", n_results, 6);
    step();
    check("drain_level_empty", bus.level, 0);

    // Wrap-around stream with toggling backpressure
    for (int k = 0; k < 12; k++)
      pend.push_back('{opcode: alu_opcode_e'(3'($urandom_range(0, 7))),
                       operand1: 8'($urandom), operand2: 8'($urandom)});
    n_results = 0;
    stream(300, 1'b1);
    check("wrap_count", n_results, 12);
    step();
    check("wrap_out_valid_idle", bus.out_valid, 0);
    check("wrap_level_empty", bus.level, 0);

    // Flush with a full FIFO during HOLD
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_cmd(fill[k]);
      step();
    end
    bus.in_valid = 1'b0;
    check("preflush_level", bus.level, 4);
    check("preflush_out_valid", bus.out_valid, 1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_level", bus.level, 0);
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_in_ready", bus.in_ready, 1);

    // A push in the flush cycle is discarded
    drive_cmd('{opcode: OP_ADD, operand1: 8'h01, operand2: 8'h01});
    bus.flush = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_push_dropped", bus.level, 0);
    step();
    step();
    check("flush_push_no_result", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    single('{OP_SUB, 8'h09, 8'h04, 16'h0005});

    // Async reset mid-DRIVE
    drive_cmd('{opcode: OP_MUL, operand1: 8'h12, operand2: 8'h34});
    step();
    drive_cmd('{opcode: OP_XOR, operand1: 8'h5A, operand2: 8'hC3});
    step();
    bus.in_valid = 1'b0;
    check("pre_rst_alu_operand1", bus.alu_operand1, 8'h12);
    check("pre_rst_level", bus.level, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_alu_operand1", bus.alu_operand1, 0);
    check("arst_alu_operand2", bus.alu_operand2, 0);
    check("arst_alu_opcode", bus.alu_opcode, 0);
    check("arst_out_result", bus.out_result, 0);
    check("arst_level", bus.level, 0);
    check("arst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    step();
    check("post_rst_out_valid", bus.out_valid, 0);
    check("post_rst_level", bus.level, 0);
    check("post_rst_in_ready", bus.in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command-issue stage that sits directly upstream of the combinational ALU and also registers its output.
- Accepts {opcode, operand1, operand2} commands over a valid/ready handshake and buffers them in a small FIFO.
- Presents one command at a time on registered ALU input ports, then captures the ALU result into a registered, handshaked output.
- Gives the ALU a clocked, back-pressurable front end so the TB environment and future pipelines can stream commands.

Parameters:
- WIDTH, 8, operand width driven to ALU Operand1/Operand2.
- RES_WIDTH, 16, ALU Result width.
- DEPTH, 4, command FIFO entries; power of two, >=2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous: drop all queued and in-flight commands.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid && in_ready.
- in_opcode  in  OPCODE_W  ALU opcode (package type).
- in_operand1  in  WIDTH  first operand.
- in_operand2  in  WIDTH  second operand.
- alu_operand1  out  WIDTH  to ALU Operand1, registered.
- alu_operand2  out  WIDTH  to ALU Operand2, registered.
- alu_opcode  out  OPCODE_W  to ALU OpCode, registered.
- alu_result  in  RES_WIDTH  from ALU Result, combinational.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_result  out  RES_WIDTH  captured result.
- out_opcode  out  OPCODE_W  opcode tag of the captured result.
- level  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the command in flight.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO pointers and level = 0; FSM = IDLE.
  - alu_*, out_result, out_opcode, out_valid = 0.
  - in_ready = 1 (FIFO empty).
- in_ready = (level != DEPTH), combinational from registered level.
- No bypass: when full, a push is refused even if a pop occurs the same cycle.
- Push and pop in the same cycle when not full: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Level is a separate counter, so full and empty are unambiguous.
- FSM states: IDLE, DRIVE, HOLD.
  - IDLE: if level > 0, pop the head into alu_* registers -> DRIVE. Otherwise stay; alu_* hold their last values.
  - DRIVE: alu_* stable for one full cycle. At the next edge capture alu_result -> out_result and alu_opcode -> out_opcode, set out_valid = 1 -> HOLD.
  - HOLD: out_valid, out_result and out_opcode are held stable until out_valid && out_ready. On that handshake, clear out_valid; if level > 0, pop the next command into alu_* -> DRIVE, else -> IDLE.
- Latency: a command accepted into an empty, idle unit at edge N is popped at N+1 and captured at N+2. out_valid is high from N+2.
- Throughput: one result per 2 cycles at best; out_valid is low for exactly one cycle between back-to-back results.
- A push into an empty FIFO is not visible to IDLE until the next edge. There is no same-cycle bypass.
- flush (sync, highest priority):
  - Next edge: level = 0, pointers = 0, out_valid = 0, FSM = IDLE.
  - A push in the flush cycle is discarded.
  - alu_*, out_result and out_opcode keep their values, and are don't-care while out_valid = 0.
- Reset mid-operation (any state): immediately returns to the reset values above; no partial result is emitted.
- Results leave in strict acceptance order. Values are not modified; widths pass through unchanged.

Decomposition:
- Shared package alu_pkg:
  - OPCODE_W = 3.
  - typedef enum alu_opcode_e, reused by the ALU, this block and the TB.
  - typedef struct alu_cmd_t {opcode, operand1, operand2}.
- One sub-module: alu_cmd_fifo (DEPTH x alu_cmd_t, push/pop/level, flush). The FSM and output register live in alu_cmd_sequencer.

Test Plan:
- Single command: push {ADD, 8'h05, 8'h03} at edge N, out_ready = 1 -> out_valid at N+2, out_result = 16'h0008, out_opcode = ADD; level back to 0.
- Fill under backpressure: out_ready = 0, push 6 commands back-to-back -> 5 accepted (1 in flight + 4 queued), in_ready = 0 after the 5th, level = 4; the 6th is held until a pop.
- Hold stability: out_ready = 0 for 10 cycles after out_valid -> out_result, out_opcode and alu_* unchanged every cycle.
- Wrap-around stream: 12 random commands with out_ready toggling 1/0 -> 12 results in order, each matching the golden ALU model; pointers wrap 3 times.
- Flush with a full FIFO during HOLD -> next cycle level = 0, out_valid = 0, in_ready = 1. A following {SUB, 8'h09, 8'h04} yields 16'h0005 two cycles after accept.
- Async reset asserted mid-DRIVE -> out_valid, alu_* and level = 0 immediately, without waiting for a clock edge. After release, the unit idles with in_ready = 1.
